tick_watchdog: RTL and testbench
================================

// Module: tick_watchdog
// PURPOSE
//  Downstream consumer of the clk_cntr terminal-count output. Rising edges of tick_in are
//  counted as timebase ticks. A kick input from the supervised logic restarts the count.
//  Missing kicks raise warn, then expired. Sits between the timebase counter and fault/reset logic.
// PARAMETERS
//  WARN_TICKS     8     ticks without kick before entering WARN; must be >= 1
//  TIMEOUT_TICKS  16    ticks without kick before entering EXPIRED; must be > WARN_TICKS
//  STICKY         1'b1  1: EXPIRED left only via enable=0; 0: kick also leaves EXPIRED
// PORTS
//  clk          in   1   system clock, single clock domain
//  reset        in   1   asynchronous, active-high reset
//  tick_in      in   1   timebase level/pulse (clk_cntr cnt_reached), synchronous to clk
//  enable       in   1   1 = watchdog armed; 0 = forced to IDLE
//  kick         in   1   1-cycle service strobe from supervised logic
//  state        out  2   current FSM state (IDLE=0, ARMED=1, WARN=2, EXPIRED=3)
//  warn         out  1   1 while state==WARN
//  expired      out  1   1 while state==EXPIRED
//  tick_cnt     out  32  ticks since last kick/arm
//  expire_count out  8   number of ARMED/WARN->EXPIRED entries, saturates at 255
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, tick_d=0, tick_cnt=0, expire_count=0.
//    warn=0, expired=0. Reset mid-operation aborts any state immediately.
//  - Edge detect: tick_d <= tick_in each clk; tick_rise = tick_in & ~tick_d. No synchroniser.
//    A tick_in held high for N cycles counts as one tick.
//  - All outputs are registered or decoded from registers. warn/expired are decoded from state.
//    A decision made on the cycle a tick_rise or kick is present is visible after the next clk edge.
//  - Priority each cycle: enable=0 > kick > tick_rise.
//  - IDLE: tick_cnt held at 0. enable=1 -> ARMED, tick_cnt=0.
//  - ARMED: enable=0 -> IDLE, tick_cnt=0. kick -> tick_cnt=0, stay.
//    On tick_rise: tick_cnt+1. If tick_cnt+1 == WARN_TICKS -> WARN.
//  - WARN: enable=0 -> IDLE, tick_cnt=0. kick -> ARMED, tick_cnt=0.
//    On tick_rise: tick_cnt+1. If tick_cnt+1 == TIMEOUT_TICKS -> EXPIRED, expire_count+1 (sat 255).
//  - EXPIRED: tick_cnt frozen; ticks ignored. enable=0 -> IDLE, tick_cnt=0.
//    If STICKY=0, kick -> ARMED, tick_cnt=0. If STICKY=1, kick is ignored.
//  - kick and tick_rise in the same cycle: kick wins, tick_cnt=0, and that tick is discarded.
//  - enable=0 together with kick/tick: IDLE, tick_cnt=0.
//  - tick_cnt cannot wrap: maximum value is TIMEOUT_TICKS. expire_count holds at 8'hFF.
//  - expire_count is cleared only by reset, not by enable=0.
// TESTING (WARN_TICKS=3, TIMEOUT_TICKS=5, tick_in = 1-cycle pulse every 4 clks unless stated)
//  1 Reset, enable=1, no kick -> ARMED one clk after enable. warn=1 the clk after the 3rd
//    tick_rise. expired=1, tick_cnt=5, expire_count=1 the clk after the 5th tick_rise.
//  2 Kick on the cycle after the 2nd tick -> tick_cnt=0, stays ARMED. Warn only after 3 further ticks.
//  3 Kick coincident with tick_rise while in WARN -> ARMED, tick_cnt=0, no EXPIRED.
//  4 STICKY=1 in EXPIRED: kick -> stays EXPIRED. enable=0 -> IDLE, tick_cnt=0, expire_count kept.
//    With STICKY=0, kick -> ARMED.
//  5 tick_in held high 10 clks -> tick_cnt increments by exactly 1.
//    Assert reset mid-WARN -> all outputs 0 asynchronously.
//  6 Force 256 expiries (enable toggling) -> expire_count saturates at 255, no wrap to 0.

Source files
------------

// File: rtl/tick_watchdog_if.sv
// Signal bundle between the supervised logic and the tick watchdog.
// The master drives the timebase, arm and kick lines; the slave (watchdog) returns its status.
interface tick_watchdog_if;
   logic        tick_in;
   logic        enable;
   logic        kick;
   logic [1:0]  state;
   logic        warn;
   logic        expired;
   logic [31:0] tick_cnt;
   logic [7:0]  expire_count;

   modport master (
      output tick_in, enable, kick,
      input  state, warn, expired, tick_cnt, expire_count
   );

   modport slave (
      input  tick_in, enable, kick,
      output state, warn, expired, tick_cnt, expire_count
   );
endinterface

// File: rtl/tick_watchdog.sv
// Watchdog that counts timebase tick edges between kicks.
// It escalates from ARMED to WARN to EXPIRED.
module tick_watchdog #(
   parameter int unsigned WARN_TICKS    = 8,
   parameter int unsigned TIMEOUT_TICKS = 16,
   parameter bit          STICKY        = 1'b1
) (
   input logic           clk,
   input logic           reset,
   tick_watchdog_if.slave bus
);

   localparam int unsigned CNT_W = 32;
   localparam int unsigned EXP_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      WARN    = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               tick_d;
   logic               tick_rise;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic               warn_q, warn_d;
   logic               expired_q, expired_d;

   assign tick_rise = bus.tick_in & ~tick_d;
   assign cnt_inc   = cnt_q + CNT_W'(1);

   // State, counters and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         tick_d    <= 1'b0;
         cnt_q     <= '0;
         exp_q     <= '0;
         warn_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_d    <= bus.tick_in;
         cnt_q     <= cnt_d;
         exp_q     <= exp_d;
         warn_q    <= warn_d;
         expired_q <= expired_d;
      end
   end

   // Next state; priority is enable=0, then kick, then tick_rise
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.enable) state_d = ARMED;
         end
         ARMED: begin
            if (!bus.enable) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus.kick) begin
               cnt_d = '0;
            end else if (tick_rise) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(WARN_TICKS)) state_d = WARN;
            end
         end
         WARN: begin
            if (!bus.enable) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus.kick) begin
               state_d = ARMED;
               cnt_d   = '0;
            end else if (tick_rise) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(TIMEOUT_TICKS)) begin
                  state_d = EXPIRED;
                  exp_d   = (exp_q == {EXP_W{1'b1}}) ? exp_q : exp_q + EXP_W'(1);
               end
            end
         end
         EXPIRED: begin
            // Count stays frozen at the timeout value while expired
            if (!bus.enable) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus.kick && !STICKY) begin
               state_d = ARMED;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      warn_d    = (state_d == WARN);
      expired_d = (state_d == EXPIRED);
   end

   assign bus.state        = state_q;
   assign bus.warn         = warn_q;
   assign bus.expired      = expired_q;
   assign bus.tick_cnt     = cnt_q;
   assign bus.expire_count = exp_q;

endmodule

// File: tb/tb_tick_watchdog.sv
// Directed bench for tick_watchdog with WARN_TICKS=3, TIMEOUT_TICKS=5.
// It drives a sticky and a non-sticky instance.
module tb_tick_watchdog;

   logic clk;
   logic reset;

   tick_watchdog_if s1 ();
   tick_watchdog_if s2 ();

   tick_watchdog #(.WARN_TICKS(3), .TIMEOUT_TICKS(5), .STICKY(1'b1)) dut (
      .clk(clk), .reset(reset), .bus(s1.slave)
   );

   tick_watchdog #(.WARN_TICKS(3), .TIMEOUT_TICKS(5), .STICKY(1'b0)) dut_ns (
      .clk(clk), .reset(reset), .bus(s2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        tick;
      logic        en;
      logic        kick;
      logic [1:0]  st;
      logic [31:0] cnt;
      logic [7:0]  ec;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all1(input string tag, input logic [1:0] st, input logic [31:0] cnt,
                           input logic [7:0] ec);
      chk({tag, ".state"},        32'(s1.state),        32'(st));
      chk({tag, ".warn"},         32'(s1.warn),         32'(st == 2'd2));
      chk({tag, ".expired"},      32'(s1.expired),      32'(st == 2'd3));
      chk({tag, ".tick_cnt"},     s1.tick_cnt,          cnt);
      chk({tag, ".expire_count"}, 32'(s1.expire_count), 32'(ec));
   endtask

   task automatic v(input int n, input logic t, input logic e, input logic k,
                    input logic [1:0] st, input logic [31:0] cnt, input logic [7:0] ec);
      vec_t r;
      r.tick = t; r.en = e; r.kick = k; r.st = st; r.cnt = cnt; r.ec = ec;
      for (int i = 0; i < n; i++) vecs.push_back(r);
   endtask

   task automatic step(input logic t, input logic e, input logic k);
      s1.tick_in = t; s1.enable = e; s1.kick = k;
      @(posedge clk); #1;
   endtask

   task automatic step2(input logic t, input logic e, input logic k);
      s2.tick_in = t; s2.enable = e; s2.kick = k;
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Vectors: one clk per entry, expected values sampled just after the edge
      v(1, 0,1,0, 2'd1, 0, 0);
      v(1, 1,1,0, 2'd1, 1, 0);
      v(3, 0,1,0, 2'd1, 1, 0);
      v(1, 1,1,0, 2'd1, 2, 0);
      v(1, 0,1,1, 2'd1, 0, 0);
      v(1, 0,1,0, 2'd1, 0, 0);
      v(1, 1,1,0, 2'd1, 1, 0);
      v(3, 0,1,0, 2'd1, 1, 0);
      v(1, 1,1,0, 2'd1, 2, 0);
      v(3, 0,1,0, 2'd1, 2, 0);
      v(1, 1,1,0, 2'd2, 3, 0);
      v(3, 0,1,0, 2'd2, 3, 0);
      v(1, 1,1,0, 2'd2, 4, 0);
      v(3, 0,1,0, 2'd2, 4, 0);
      v(1, 1,1,1, 2'd1, 0, 0);
      v(3, 0,1,0, 2'd1, 0, 0);
      v(1, 1,1,0, 2'd1, 1, 0);
      v(1, 0,1,0, 2'd1, 1, 0);
      v(1, 1,1,0, 2'd1, 2, 0);
      v(1, 0,1,0, 2'd1, 2, 0);
      v(1, 1,1,0, 2'd2, 3, 0);
      v(1, 0,1,0, 2'd2, 3, 0);
      v(1, 1,1,0, 2'd2, 4, 0);
      v(1, 0,1,0, 2'd2, 4, 0);
      v(1, 1,1,0, 2'd3, 5, 1);
      v(1, 0,1,0, 2'd3, 5, 1);
      v(1, 1,1,0, 2'd3, 5, 1);
      v(1, 0,1,1, 2'd3, 5, 1);
      v(1, 0,0,0, 2'd0, 0, 1);
      v(1, 1,0,0, 2'd0, 0, 1);
      v(1, 0,1,0, 2'd1, 0, 1);
      v(10,1,1,0, 2'd1, 1, 1);
      v(1, 0,1,0, 2'd1, 1, 1);

      s1.tick_in = 0; s1.enable = 0; s1.kick = 0;
      s2.tick_in = 0; s2.enable = 0; s2.kick = 0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_all1("reset", 2'd0, 0, 0);
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         step(vecs[i].tick, vecs[i].en, vecs[i].kick);
         chk_all1($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt, vecs[i].ec);
      end
      step(0, 0, 0);

      // Non-sticky instance: kick leaves EXPIRED
      step2(0, 1, 0);
      chk("ns.armed", 32'(s2.state), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step2(1, 1, 0);
         step2(0, 1, 0);
      end
      chk("ns.state_exp", 32'(s2.state), 32'd3);
      chk("ns.expired",   32'(s2.expired), 32'd1);
      chk("ns.cnt_exp",   s2.tick_cnt, 32'd5);
      chk("ns.ec_exp",    32'(s2.expire_count), 32'd1);
      step2(0, 1, 1);
      chk("ns.kick_state", 32'(s2.state), 32'd1);
      chk("ns.kick_cnt",   s2.tick_cnt, 32'd0);
      chk("ns.kick_ec",    32'(s2.expire_count), 32'd1);
      step2(1, 1, 0);
      chk("ns.recount", s2.tick_cnt, 32'd1);
      step2(0, 0, 0);

      // Asynchronous reset while in WARN
      step(0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0);
         step(0, 1, 0);
      end
      chk("mid.warn_before", 32'(s1.warn), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_all1("async_rst", 2'd0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      s1.enable = 0;
      @(posedge clk); #1;

      // Saturation of expire_count over 256 expiries
      for (int n = 1; n <= 256; n++) begin
         step(0, 1, 0);
         for (int i = 0; i < 5; i++) begin
            step(1, 1, 0);
            step(0, 1, 0);
         end
         if (n == 1)   chk("sat.first", 32'(s1.expire_count), 32'd1);
         if (n == 255) chk_all1("sat.255", 2'd3, 5, 8'd255);
         if (n == 256) chk_all1("sat.256", 2'd3, 5, 8'd255);
         step(0, 0, 0);
      end
      chk_all1("sat.idle", 2'd0, 0, 8'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
